// File: rtl/fp_pkg.sv
// fp_pkg: constants and types shared by the floating-point ALU units
package fp_pkg;
    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [1:0]  ESP_OK   = 2'b00;
    localparam logic [1:0]  ESP_INV  = 2'b01;
    localparam logic [1:0]  ESP_DIV0 = 2'b10;
    localparam logic [1:0]  ESP_OVUF = 2'b11;
    typedef enum logic [1:0] {ZERO, INF, NAN, NORM} fp_class_t;
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} div_state_t;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: single-precision operand class, subnormals counted as zero
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] x,
    output fp_class_t   cls
);
    assign cls = x[30:23] == 8'd0 ? ZERO : x[30:23] != 8'hFF ? NORM : x[22:0] == 23'd0 ? INF : NAN;
endmodule

// File: rtl/alu_div.sv
// alu_div: sequential single-precision divider, restoring mantissa division, truncated result
module alu_div
    import fp_pkg::*;
#(
    parameter int ITER = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] Resultado,
    output logic [1:0]  esp
);
    div_state_t         state, state_next;
    fp_class_t          ca, cb;
    logic [4:0]         cnt;
    logic [24:0]        rem, q;
    logic [23:0]        mb;
    logic signed [9:0]  e, ex;
    logic               sgn, sgn_r, accept, special, inv, ge;
    logic [31:0]        spec_res, norm_res;
    logic [1:0]         spec_esp, norm_esp;
    logic [22:0]        fr;

    fp_classify u_ca (.x(dataA), .cls(ca));
    fp_classify u_cb (.x(dataB), .cls(cb));

    assign busy    = state != S_IDLE;
    assign accept  = start && !busy;
    assign sgn     = dataA[31] ^ dataB[31];
    assign special = !(ca == NORM && cb == NORM);
    assign inv     = ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF);
    assign ge      = rem >= {1'b0, mb};
    assign ex      = q[24] ? e : e - 10'sd1;
    assign fr      = q[24] ? q[23:1] : q[22:0];

    always_comb begin
        spec_res   = inv ? QNAN : (ca == NORM && cb == ZERO) || ca == INF ? {sgn, 8'hFF, 23'd0} : {sgn, 31'd0};
        spec_esp   = inv ? ESP_INV : ca == NORM && cb == ZERO ? ESP_DIV0 : ESP_OK;
        norm_res   = ex >= 10'sd255 ? {sgn_r, 8'hFF, 23'd0} : ex <= 10'sd0 ? {sgn_r, 31'd0} : {sgn_r, ex[7:0], fr};
        norm_esp   = ex >= 10'sd255 || ex <= 10'sd0 ? ESP_OVUF : ESP_OK;
        state_next = state == S_IDLE ? (accept && !special ? S_DIV : S_IDLE) :
                     state == S_DIV  ? (cnt == 5'd0 ? S_NORM : S_DIV) : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            q         <= '0;
            mb        <= '0;
            e         <= '0;
            sgn_r     <= 1'b0;
            done      <= 1'b0;
            Resultado <= '0;
            esp       <= ESP_OK;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (accept) begin
                sgn_r <= sgn;
                rem   <= {2'b01, dataA[22:0]};
                mb    <= {1'b1, dataB[22:0]};
                q     <= '0;
                cnt   <= 5'(ITER - 1);
                e     <= {2'b00, dataA[30:23]} - {2'b00, dataB[30:23]} + 10'(EXP_BIAS);
                if (special) begin
                    Resultado <= spec_res;
                    esp       <= spec_esp;
                    done      <= 1'b1;
                end
            end
            if (state == S_DIV) begin
                rem <= (ge ? rem - {1'b0, mb} : rem) << 1;
                q   <= {q[23:0], ge};
                cnt <= cnt - 5'd1;
            end
            if (state == S_NORM) begin
                Resultado <= norm_res;
                esp       <= norm_esp;
                done      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: directed vectors for alu_div with hand-computed quotients and cycle counts
module tb_alu_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        busy, done;
    logic [31:0] Resultado;
    logic [1:0]  esp;
    int          n_assert = 0;
    int          n_fail = 0;
    int          lat, seen;
    bit          bok;

    alu_div dut (.clk(clk), .rst(rst), .start(start), .dataA(dataA), .dataB(dataB),
                 .busy(busy), .done(done), .Resultado(Resultado), .esp(esp));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int l, output bit ok);
        l = 1;
        ok = 1'b1;
        while (!done && l < 60) begin
            if (!busy) ok = 1'b0;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [1:0] e, input int lat_exp);
        int  l;
        bit  ok;
        dataA = a; dataB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dataA = 32'h7FC00001; dataB = 32'h0;
        wait_done(l, ok);
        chk({tag, "_lat"}, l, lat_exp);
        chk({tag, "_res"}, Resultado, res);
        chk({tag, "_esp"}, {30'd0, esp}, {30'd0, e});
        if (lat_exp == 27) chk({tag, "_busy"}, {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, Resultado, res);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", Resultado, 32'd0);
        chk("rst_esp", {30'd0, esp}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 27);
        run("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 2'b00, 27);
        run("neg_third", 32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 2'b00, 27);
        run("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 2'b10, 1);
        run("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 2'b01, 1);
        run("inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b01, 1);
        run("inf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, 2'b00, 1);
        run("fin_inf", 32'h40000000, 32'hFF800000, 32'h80000000, 2'b00, 1);
        run("subn_num", 32'h00400000, 32'h40000000, 32'h00000000, 2'b00, 1);
        run("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 2'b11, 27);
        run("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 2'b11, 27);

        dataA = 32'h40C00000; dataB = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res", Resultado, 32'd0);
        chk("abort_esp", {30'd0, esp}, 32'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        chk("abort_nodone", seen, 0);
        run("after_abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 2'b00, 27);

        rst = 1'b1; start = 1'b1; dataA = 32'h3F800000; dataB = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        dataA = 32'h40C00000; dataB = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        dataA = 32'h00000000; dataB = 32'h00000000;
        wait_done(lat, bok);
        chk("b2b_first_lat", lat, 27);
        chk("b2b_first_res", Resultado, 32'h40400000);
        chk("b2b_first_esp", {30'd0, esp}, 32'd0);
        dataA = 32'h3F800000; dataB = 32'h40400000;
        @(posedge clk); #1;
        dataA = 32'h7F800000; dataB = 32'h7F800000;
        wait_done(lat, bok);
        start = 1'b0;
        chk("b2b_second_lat", lat, 27);
        chk("b2b_second_res", Resultado, 32'h3EAAAAAA);
        chk("b2b_second_busy", {31'd0, bok}, 32'd1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_div.md
# alu_div

Sequential IEEE-754 single-precision divider, the inverse operation of the combinational multiplier `alu_mult` on the ALU floating-point path. It accepts `dataA / dataB` on a start/busy/done handshake and divides mantissas with a bit-serial restoring divider. It returns a truncated result plus the same 2-bit `esp` exception code the multiplier exposes. Subnormal inputs are flushed to zero; there is no rounding, matching the multiplier's truncation.

## Interface
Parameters:
- `ITER`, 25: restoring-division iterations (24-bit mantissa plus 1 normalization bit); not intended to be changed.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted when `start && !busy`.
- `dataA`  in  32  dividend, sampled on acceptance.
- `dataB`  in  32  divisor, sampled on acceptance.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `Resultado` and `esp` are valid.
- `Resultado`  out  32  quotient, held until the next `done`.
- `esp`  out  2  exception code: 00 normal, 01 invalid/NaN, 10 divide-by-zero, 11 overflow/underflow.

## Operation
- Operand classes, checked in the acceptance cycle:
  - zero: exp==0, including subnormals.
  - inf: exp==255, frac==0.
  - NaN: exp==255, frac!=0.
  - normal: everything else.
- Sign is always `dataA[31]^dataB[31]`, except for NaN results.
- Special-case priority, resolved without iterating:
  1. Either operand NaN, 0/0, or inf/inf → `32'h7FC00000`, esp=01.
  2. Finite nonzero / zero → signed inf, esp=10.
  3. inf / finite → signed inf, esp=00.
  4. zero / nonzero, or finite / inf → signed zero, esp=00.
- Normal path:
  - Dividend mantissa `mA={1,fracA}`, divisor mantissa `mB={1,fracB}`.
  - Partial remainder starts at `mA`. Each DIV cycle: if rem ≥ mB then subtract and qbit=1, else qbit=0; then rem<<=1. Quotient bits fill q[24] down to q[0].
  - Exponent uses a 10-bit signed `e = eA - eB + 127`.
  - NORM stage: if q[24]=1, frac=q[23:1] and exp=e; otherwise frac=q[22:0] and exp=e-1. Remainder bits are discarded (truncation).
  - exp ≥ 255 → signed inf, esp=11.
  - exp ≤ 0 → signed zero, esp=11.
- FSM states IDLE, DIV, NORM:
  - IDLE → DIV on normal acceptance, counter loaded with ITER-1.
  - DIV decrements the counter; DIV → NORM when counter==0.
  - NORM → IDLE, registering the result.
  - Special-case acceptance stays in IDLE and registers the result directly.
- `busy = (state != IDLE)`. `start` while busy is ignored; operands are not re-sampled.

## Timing
- Acceptance cycle C. Normal path: DIV occupies C+1..C+25, NORM C+26, `done`=1 and result visible at C+27.
- Special cases: `done`=1 at C+1.
- `done` is high exactly one cycle. A `start` in the `done` cycle is accepted (back-to-back, no bubble).
- Reset values: state=IDLE, `busy`=0, `done`=0, `Resultado`=0, `esp`=00, counter=0.
- `rst` mid-operation: the operation is abandoned and no `done` is produced. Outputs return to reset values the next cycle; a new `start` after reset deasserts behaves normally.
- `rst` and `start` in the same cycle: reset wins and the request is dropped.
- Inputs may change freely after acceptance with no effect on the result.

## Structure
- Shared package `fp_pkg` (also used by `alu_mult`):
  - `EXP_BIAS=127`, `QNAN=32'h7FC00000`.
  - `esp` code constants `ESP_OK`, `ESP_INV`, `ESP_DIV0`, `ESP_OVUF`.
  - Operand-class enum (ZERO, INF, NAN, NORM).
  - FSM state enum.
- Sub-module `fp_classify` (combinational, 32-bit in → class enum), instantiated twice here and reusable by `alu_mult`.
- The divider datapath (remainder, quotient shift register, counter) stays inline.

## Test plan
- `0x40C00000 / 0x40000000` (6/2) → `Resultado=0x40400000`, esp=00, busy high C+1..C+26, done at C+27 only.
- `0x3F800000 / 0x40400000` (1/3) → `0x3EAAAAAA` (truncated, not AB), esp=00; `0xBF800000 / 0x40400000` → `0xBEAAAAAA`.
- `0x3F800000 / 0x00000000` → `0x7F800000`, esp=10, done at C+1; `0x00000000 / 0x00000000` → `0x7FC00000`, esp=01; `0x7F800000 / 0x7F800000` → `0x7FC00000`, esp=01.
- `0x7F000000 / 0x3E800000` → `0x7F800000`, esp=11; `0x00800000 / 0x7F000000` → `0x00000000`, esp=11.
- Start 6/2, pulse `rst` at C+10: no done ever asserts for it, busy=0 at C+11. Then start 1/3: done at its C+27 with `0x3EAAAAAA`.
- Back-to-back: hold `start` high with 6/2 then 1/3 presented in the first done cycle. The second result arrives exactly 27 cycles later. A `start` issued while busy changes nothing.
